// File: rtl/alu_muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_muldiv_sequencer_pkg
// Shared constants and types for the multiply/divide sequencer:
//   - ALU control codes the sequencer drives while it owns the ALU
//   - op encodings sampled with start
//   - sequencer state enum
// -----------------------------------------------------------------------------
package alu_muldiv_sequencer_pkg;

  localparam int DATA_W = 16;

  // ALU control codes used by the sequencer
  localparam logic [4:0] ALU_PASS_A = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd2;
  localparam logic [4:0] ALU_SUB    = 5'd3;

  // Operation select sampled with start
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_sequencer_alu_port_mux.sv
// -----------------------------------------------------------------------------
// alu_port_mux
// 2:1 select of the ALU control/operand ports between the pipeline and the
// multiply/divide sequencer.
// Ports:
//   i_sel_seq                 1 = sequencer drives the ALU, 0 = pipeline
//   i_pipe_ctrl/_a/_b         pipeline ALU control and operands
//   i_seq_ctrl/_a/_b          sequencer ALU control and operands
//   o_ctrl/o_a/o_b            to ALU ctrl, operand A, operand B
// -----------------------------------------------------------------------------
module alu_port_mux
  import alu_muldiv_sequencer_pkg::*;
(
  input  logic              i_sel_seq,
  input  logic [4:0]        i_pipe_ctrl,
  input  logic [DATA_W-1:0] i_pipe_a,
  input  logic [DATA_W-1:0] i_pipe_b,
  input  logic [4:0]        i_seq_ctrl,
  input  logic [DATA_W-1:0] i_seq_a,
  input  logic [DATA_W-1:0] i_seq_b,
  output logic [4:0]        o_ctrl,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b
);

  assign o_ctrl = i_sel_seq ? i_seq_ctrl : i_pipe_ctrl;
  assign o_a    = i_sel_seq ? i_seq_a    : i_pipe_a;
  assign o_b    = i_sel_seq ? i_seq_b    : i_pipe_b;

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// alu_muldiv_sequencer
// Multi-cycle unsigned 16x16 multiply (MULTU) and 16/16 divide (DIVU) using
// the shared external ALU, one ALU operation per cycle. In IDLE the pipeline
// drives the ALU directly; during RUN the sequencer owns the ALU and the
// pipeline is stalled via o_busy.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_op             request pulse (IDLE only), 0=MULTU 1=DIVU
//   i_src_a, i_src_b          multiplicand/dividend, multiplier/divisor
//   i_pipe_ctrl/_a/_b         pipeline ALU control and operands
//   o_alu_ctrl/_a/_b          to ALU
//   i_alu_result              from ALU, consumed in the same cycle
//   o_busy, o_done            stall request, one-cycle result-valid pulse
//   o_div_zero                last DIVU had a zero divisor
//   o_hi, o_lo                product high/low or remainder/quotient
// -----------------------------------------------------------------------------
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_op,
  input  logic [DATA_W-1:0] i_src_a,
  input  logic [DATA_W-1:0] i_src_b,
  input  logic [4:0]        i_pipe_ctrl,
  input  logic [DATA_W-1:0] i_pipe_a,
  input  logic [DATA_W-1:0] i_pipe_b,
  output logic [4:0]        o_alu_ctrl,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_op;
  logic [DATA_W-1:0]   r_opnd;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [3:0]          r_cnt;
  logic                r_div_zero;

  logic                w_sel_seq;
  logic                w_div_by_zero;
  logic [4:0]          w_seq_ctrl;
  logic [DATA_W-1:0]   w_seq_a;
  logic [DATA_W-1:0]   w_seq_b;
  logic [DATA_W-1:0]   w_sh;
  logic                w_carry;
  logic                w_ge;
  logic [DATA_W-1:0]   w_hi_next;
  logic [DATA_W-1:0]   w_lo_next;

  assign w_div_by_zero = (i_op == OP_DIVU) && (i_src_b == '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_sel_seq    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = w_div_by_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        o_busy    = 1'b1;
        w_sel_seq = 1'b1;
        if (r_cnt == 4'd0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // Stall still asserted, but the ALU is already handed back
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-cycle step: ALU drive and next hi/lo
  // ---------------------------------------------------------------------------
  assign w_sh = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};

  always_comb begin
    w_seq_ctrl = ALU_PASS_A;
    w_seq_a    = r_hi;
    w_seq_b    = r_opnd;
    w_carry    = 1'b0;
    w_ge       = 1'b0;
    w_hi_next  = r_hi;
    w_lo_next  = r_lo;
    if (r_op == OP_MULTU) begin
      // Shift-add: add multiplicand into hi when the current multiplier bit
      // is set; the ALU add wraps, so the carry is recovered by comparison.
      if (r_lo[0]) w_seq_ctrl = ALU_ADD;
      w_carry   = r_lo[0] & (i_alu_result < r_hi);
      w_hi_next = {w_carry, i_alu_result[DATA_W-1:1]};
      w_lo_next = {i_alu_result[0], r_lo[DATA_W-1:1]};
    end else begin
      // Restoring division; the bit shifted out of hi (top) makes the
      // 17-bit partial remainder always >= divisor.
      w_seq_ctrl = ALU_SUB;
      w_seq_a    = w_sh;
      w_ge       = r_hi[DATA_W-1] | ~(w_sh < r_opnd);
      w_hi_next  = w_ge ? i_alu_result : w_sh;
      w_lo_next  = {r_lo[DATA_W-2:0], w_ge};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= OP_MULTU;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= 4'd0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op   <= i_op;
            r_opnd <= i_src_b;
            r_cnt  <= 4'd15;
            if (w_div_by_zero) begin
              r_hi       <= i_src_a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else begin
              r_hi       <= '0;
              r_lo       <= i_src_a;
              r_div_zero <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_hi <= w_hi_next;
          r_lo <= w_lo_next;
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

  alu_port_mux u_alu_port_mux (
    .i_sel_seq   (w_sel_seq),
    .i_pipe_ctrl (i_pipe_ctrl),
    .i_pipe_a    (i_pipe_a),
    .i_pipe_b    (i_pipe_b),
    .i_seq_ctrl  (w_seq_ctrl),
    .i_seq_a     (w_seq_a),
    .i_seq_b     (w_seq_b),
    .o_ctrl      (o_alu_ctrl),
    .o_a         (o_alu_a),
    .o_b         (o_alu_b)
  );

endmodule
